// File: rtl/raster_gpu.sv
// raster_gpu: rectangle fill / screen clear engine feeding a framebuffer
// write port with one pixel per enabled clock.
// Optional feature macro: RASTER_GPU_CLIP_EN clamps rectangles to the
// visible screen so that no write ever falls outside it.
module raster_gpu #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int PIXEL_WIDTH       = 1,
  localparam int XW               = $clog2(HOR_ACTIVE_PIXELS),
  localparam int YW               = $clog2(VER_ACTIVE_PIXELS),
  localparam int WR_ADDR_WIDTH    = $clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     op_kind,
  input  logic [XW:0]              op_x,
  input  logic [XW:0]              op_w,
  input  logic [YW:0]              op_y,
  input  logic [YW:0]              op_h,
  input  logic [PIXEL_WIDTH-1:0]   op_color,
  input  logic                     op_valid,
  output logic                     op_ready,
  output logic                     wr_en,
  output logic [WR_ADDR_WIDTH-1:0] wr_addr,
  output logic [PIXEL_WIDTH-1:0]   wr_data,
  output logic                     busy
);

  // Coordinate widths carry one bit beyond the operand width so x+w / y+h never wrap.
  localparam int CXW = XW + 2;
  localparam int CYW = YW + 2;
  localparam int PW  = CXW + CYW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Latched operation
  logic                   kind_reg;
  logic [XW:0]            x_reg, w_reg;
  logic [YW:0]            y_reg, h_reg;
  logic [PIXEL_WIDTH-1:0] color_reg;

  // Effective rectangle and raster cursor
  logic [CXW-1:0] x0_reg, x1_reg, cur_x_reg;
  logic [CYW-1:0] y1_reg, cur_y_reg;

  logic [WR_ADDR_WIDTH-1:0] wr_addr_reg;
  logic [PIXEL_WIDTH-1:0]   wr_data_reg;

  logic [CXW-1:0] setup_x0, setup_x1;
  logic [CYW-1:0] setup_y0, setup_y1;
  logic           setup_empty;

  logic [CXW-1:0] x_inc, nxt_x;
  logic [CYW-1:0] y_inc, nxt_y;
  logic           last_col, last_pix;

  // Linear framebuffer address, truncated to the write port width.
  function automatic logic [WR_ADDR_WIDTH-1:0] pixel_addr(input logic [CXW-1:0] px,
                                                          input logic [CYW-1:0] py);
    logic [PW-1:0] full;
    full = PW'(py) * PW'(HOR_ACTIVE_PIXELS) + PW'(px);
    return full[WR_ADDR_WIDTH-1:0];
  endfunction

  // Effective rectangle derived from the latched op (used while in SETUP).
  always_comb begin
    setup_x0 = '0;
    setup_y0 = '0;
    setup_x1 = CXW'(HOR_ACTIVE_PIXELS);
    setup_y1 = CYW'(VER_ACTIVE_PIXELS);
    if (!kind_reg) begin
      setup_x0 = CXW'(x_reg);
      setup_y0 = CYW'(y_reg);
      setup_x1 = CXW'(x_reg) + CXW'(w_reg);
      setup_y1 = CYW'(y_reg) + CYW'(h_reg);
`ifdef RASTER_GPU_CLIP_EN
      if (setup_x1 > CXW'(HOR_ACTIVE_PIXELS)) setup_x1 = CXW'(HOR_ACTIVE_PIXELS);
      if (setup_y1 > CYW'(VER_ACTIVE_PIXELS)) setup_y1 = CYW'(VER_ACTIVE_PIXELS);
`endif
    end
    setup_empty = (setup_x1 <= setup_x0) || (setup_y1 <= setup_y0);
`ifdef RASTER_GPU_CLIP_EN
    if (!kind_reg && ((CXW'(x_reg) >= CXW'(HOR_ACTIVE_PIXELS)) ||
                      (CYW'(y_reg) >= CYW'(VER_ACTIVE_PIXELS))))
      setup_empty = 1'b1;
`endif
  end

  // Row-major cursor advance: step x, wrap to x0 and bump y at the row end.
  always_comb begin
    x_inc    = cur_x_reg + CXW'(1);
    y_inc    = cur_y_reg + CYW'(1);
    last_col = (x_inc >= x1_reg);
    last_pix = last_col && (y_inc >= y1_reg);
    nxt_x    = last_col ? x0_reg : x_inc;
    nxt_y    = last_col ? y_inc : cur_y_reg;
  end

  // Next-state logic for the IDLE -> SETUP -> DRAW sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (op_valid) state_next = SETUP;
      SETUP:   state_next = setup_empty ? IDLE : DRAW;
      DRAW:    if (last_pix) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; only advances on enabled cycles.
  always_ff @(posedge clk) begin
    if (rst)     state_reg <= IDLE;
    else if (ce) state_reg <= state_next;
  end

  // Capture the op fields on acceptance so the caller may drop them afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      kind_reg  <= 1'b0;
      x_reg     <= '0;
      w_reg     <= '0;
      y_reg     <= '0;
      h_reg     <= '0;
      color_reg <= '0;
    end else if (ce && (state_reg == IDLE) && op_valid) begin
      kind_reg  <= op_kind;
      x_reg     <= op_x;
      w_reg     <= op_w;
      y_reg     <= op_y;
      h_reg     <= op_h;
      color_reg <= op_color;
    end
  end

  // Rectangle bounds, raster cursor and the registered write address/data.
  // The first pixel is loaded at the SETUP edge so it is presented during
  // the first DRAW cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      x0_reg      <= '0;
      x1_reg      <= '0;
      y1_reg      <= '0;
      cur_x_reg   <= '0;
      cur_y_reg   <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else if (ce) begin
      if (state_reg == SETUP && !setup_empty) begin
        x0_reg      <= setup_x0;
        x1_reg      <= setup_x1;
        y1_reg      <= setup_y1;
        cur_x_reg   <= setup_x0;
        cur_y_reg   <= setup_y0;
        wr_addr_reg <= pixel_addr(setup_x0, setup_y0);
        wr_data_reg <= color_reg;
      end else if (state_reg == DRAW && !last_pix) begin
        cur_x_reg   <= nxt_x;
        cur_y_reg   <= nxt_y;
        wr_addr_reg <= pixel_addr(nxt_x, nxt_y);
      end
    end
  end

  // A DRAW cycle writes its pixel only if the cycle is enabled.
  assign wr_en    = (state_reg == DRAW) && ce;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;
  assign busy     = (state_reg != IDLE);
  assign op_ready = (state_reg == IDLE) && !rst;

endmodule

// File: doc/raster_gpu.md
RASTER_GPU -- requirements
Module: raster_gpu

Interface
REQ-001 Parameter HOR_ACTIVE_PIXELS, default 640, screen width in pixels.
REQ-002 Parameter VER_ACTIVE_PIXELS, default 480, screen height in pixels.
REQ-003 Parameter PIXEL_WIDTH, default 1, bits per framebuffer pixel.
REQ-004 Derived widths SHALL be: XW=$clog2(HOR_ACTIVE_PIXELS), YW=$clog2(VER_ACTIVE_PIXELS), WR_ADDR_WIDTH=$clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS).
REQ-005 clk  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 ce  in  1  clock enable; all state SHALL advance only when ce=1.
REQ-008 op_kind  in  1  0=FILL_RECT, 1=CLEAR (whole screen).
REQ-009 op_x, op_w  in  XW+1  rectangle left edge and width.
REQ-010 op_y, op_h  in  YW+1  rectangle top edge and height.
REQ-011 op_color  in  PIXEL_WIDTH  fill value.
REQ-012 op_valid  in  1  op fields valid; op_ready  out  1  block can accept an op.
REQ-013 wr_en  out  1  framebuffer write strobe; wr_addr  out  WR_ADDR_WIDTH  pixel address; wr_data  out  PIXEL_WIDTH  pixel value.
REQ-014 busy  out  1  high from op acceptance until the last pixel of that op is written.

Function
REQ-015 States SHALL be IDLE, SETUP, DRAW; transitions occur only on cycles with ce=1.
REQ-016 op_ready SHALL be combinationally high exactly when state=IDLE and rst=0.
REQ-017 An op SHALL be accepted on a cycle with ce=1, op_valid=1, op_ready=1; fields are latched and state goes to SETUP.
REQ-018 op_valid while op_ready=0 SHALL be ignored; fields need not be held after acceptance.
REQ-019 SETUP SHALL compute the effective rectangle (CLEAR: x0=0, y0=0, x1=HOR_ACTIVE_PIXELS, y1=VER_ACTIVE_PIXELS; FILL_RECT: x1=op_x+op_w, y1=op_y+op_h, with one extra bit of width so sums never wrap).
REQ-020 If the effective rectangle is empty (x1<=x0 or y1<=y0) SETUP SHALL return to IDLE with no write.
REQ-021 Otherwise DRAW SHALL emit one pixel per ce cycle in row-major order: x from x0 to x1-1, then y increments, x returns to x0.
REQ-022 For each DRAW pixel: wr_en=1, wr_addr=y*HOR_ACTIVE_PIXELS+x, wr_data=latched op_color, all registered outputs.
REQ-023 The first write SHALL appear on the ce cycle after SETUP; an op of w*h pixels SHALL take exactly 1+w*h ce cycles from acceptance to return to IDLE.
REQ-024 After the pixel (x1-1, y1-1) state SHALL return to IDLE; op_ready SHALL be high on the next cycle (back-to-back ops gap = 1 ce cycle of IDLE).
REQ-025 Cycles with ce=0 SHALL hold all state and drive wr_en=0; wr_addr/wr_data hold their values.
REQ-026 wr_en SHALL be 0 in IDLE and SETUP.
REQ-027 busy SHALL equal (state!=IDLE).

Reset
REQ-028 rst=1 SHALL, regardless of ce, force state=IDLE, wr_en=0, wr_addr=0, wr_data=0, busy=0, and discard any op in progress, including mid-DRAW.
REQ-029 op_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst deasserts.

Configuration
REQ-030 Macro RASTER_GPU_CLIP_EN defined: SETUP SHALL clamp x1 to HOR_ACTIVE_PIXELS and y1 to VER_ACTIVE_PIXELS, and an op with op_x>=HOR_ACTIVE_PIXELS or op_y>=VER_ACTIVE_PIXELS SHALL produce no writes; no write ever leaves the screen.
REQ-031 Macro undefined: no clamp logic; FILL_RECT SHALL be drawn exactly as specified, out-of-screen coordinates are a caller error and wr_addr is the truncated product/sum.

Verification
REQ-032 Reset, then FILL_RECT x=2,y=3,w=2,h=2,color=1, ce=1 -> writes at addr 1922,1923,2562,2563 on cycles 2..5 after accept; op_ready high at cycle 6.
REQ-033 FILL_RECT w=0,h=5 -> no wr_en pulse, op_ready high 2 cycles after accept.
REQ-034 CLEAR color=1 -> exactly 307200 writes, addr 0..307199 ascending, busy low after last.
REQ-035 FILL_RECT x=638,y=0,w=4,h=1 with RASTER_GPU_CLIP_EN -> writes only 638,639; without macro -> writes 638,639,640,641.
REQ-036 ce toggled 1,0,1,0 during DRAW of w=3,h=1 -> wr_en only on ce=1 cycles, addresses consecutive, no pixel skipped or repeated.
REQ-037 rst asserted after 2nd pixel of w=4,h=1 -> wr_en=0 next cycle, no further writes, op_ready=1 after rst release.
